// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the ID/EX/WB stage register bank.
// It detects load-use hazards and taken-branch redirects, and drives the PC
// enable, ID hold and bubble/squash controls. It also latches the operand
// forward selects, halts on a non-zero tohost write and keeps saturating
// stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic [4:0]       rd_EX,
  input  logic             WrEn_RF_EX,
  input  logic             is_load_EX,
  input  logic [4:0]       rd_WB,
  input  logic             WrEn_RF_WB,
  input  logic             PC_Mux_EX,
  input  logic             tohost_we,
  input  logic [31:0]      csrw_result,
  output logic             pc_en,
  output logic             id_en,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a_EX,
  output logic [1:0]       fwd_b_EX,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   lu;
  logic   hr;
  logic   stall_inc;
  logic   flush_inc;

  // A load in EX whose destination feeds an operand used in ID cannot be
  // forwarded in time; x0 never creates a dependency.
  assign lu = is_load_EX & WrEn_RF_EX & (rd_EX != 5'd0) &
              ((rs1_used_ID & (rs1_ID == rd_EX)) |
               (rs2_used_ID & (rs2_ID == rd_EX)));

  // Only a non-zero value written to tohost ends the run.
  assign hr = tohost_we & (csrw_result != 32'd0);

  // Forward select for one operand: the younger EX producer wins over WB.
  function automatic logic [1:0] fwd_sel(
    input logic       used,
    input logic [4:0] rs,
    input logic [4:0] rd_ex,
    input logic       we_ex,
    input logic [4:0] rd_wb,
    input logic       we_wb
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (rs != 5'd0)) begin
      if (we_ex && (rd_ex == rs)) begin
        sel = 2'b01;
      end else if (we_wb && (rd_wb == rs)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  // Sequencing controls and next state; the defaults double as the
  // safe values held while reset is asserted and while halted.
  always_comb begin
    pc_en     = 1'b0;
    id_en     = 1'b0;
    flush_id  = 1'b1;
    flush_ex  = 1'b1;
    state_nxt = state;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          flush_ex = 1'b0;
          if (hr) begin
            state_nxt = HALT;
          end else if (PC_Mux_EX) begin
            pc_en     = 1'b1;
            id_en     = 1'b1;
            flush_inc = 1'b1;
            state_nxt = REDIR;
          end else if (lu) begin
            stall_inc = 1'b1;
          end else begin
            pc_en    = 1'b1;
            id_en    = 1'b1;
            flush_id = 1'b0;
          end
        end
        REDIR: begin
          flush_ex = 1'b0;
          if (hr) begin
            state_nxt = HALT;
          end else begin
            pc_en     = 1'b1;
            id_en     = 1'b1;
            flush_inc = 1'b1;
            state_nxt = RUN;
          end
        end
        HALT: begin
          state_nxt = HALT;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // State register plus the halted flag, which tracks entry into HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == HALT);
    end
  end

  // Forward selects travel into EX with the operands; bubbles carry 00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_EX <= 2'b00;
      fwd_b_EX <= 2'b00;
    end else if (flush_id || !id_en) begin
      fwd_a_EX <= 2'b00;
      fwd_b_EX <= 2'b00;
    end else begin
      fwd_a_EX <= fwd_sel(rs1_used_ID, rs1_ID, rd_EX, WrEn_RF_EX, rd_WB, WrEn_RF_WB);
      fwd_b_EX <= fwd_sel(rs2_used_ID, rs2_ID, rd_EX, WrEn_RF_EX, rd_WB, WrEn_RF_WB);
    end
  end

  // Saturating performance counters; HALT never raises an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall_inc && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush_inc && (flush_cycles != {CNT_W{1'b1}})) begin
        flush_cycles <= flush_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [4:0]       rs1_ID, rs2_ID;
  logic             rs1_used_ID, rs2_used_ID;
  logic [4:0]       rd_EX;
  logic             WrEn_RF_EX, is_load_EX;
  logic [4:0]       rd_WB;
  logic             WrEn_RF_WB;
  logic             PC_Mux_EX;
  logic             tohost_we;
  logic [31:0]      csrw_result;
  logic             pc_en, id_en, flush_id, flush_ex;
  logic [1:0]       fwd_a_EX, fwd_b_EX;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles, flush_cycles;

  int total_checks  = 0;
  int passed_checks = 0;
  bit quiet         = 0;

  // Behavioural model: "pending redirect" and "halted" flags plus counts.
  bit m_redir;
  bit m_halted;
  int m_fwd_a, m_fwd_b;
  int m_stall, m_flush;

  // Controls observed just before the most recent clock edge.
  logic pre_pc_en, pre_id_en, pre_flush_id, pre_flush_ex;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_EX(rd_EX), .WrEn_RF_EX(WrEn_RF_EX), .is_load_EX(is_load_EX),
    .rd_WB(rd_WB), .WrEn_RF_WB(WrEn_RF_WB),
    .PC_Mux_EX(PC_Mux_EX), .tohost_we(tohost_we), .csrw_result(csrw_result),
    .pc_en(pc_en), .id_en(id_en), .flush_id(flush_id), .flush_ex(flush_ex),
    .fwd_a_EX(fwd_a_EX), .fwd_b_EX(fwd_b_EX), .halted(halted),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got === exp) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fwdModel(input bit used, input int rs, input int rdex,
                                  input bit wex, input int rdwb, input bit wwb);
    if (!used || rs == 0) return 0;
    if (wex && rdex == rs) return 1;
    if (wwb && rdwb == rs) return 2;
    return 0;
  endfunction

  // Drive one cycle of inputs (called at a falling edge), check the
  // same-cycle controls, clock, then check the registered outputs.
  task automatic applyStimulus(
    input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
    input logic [4:0] rdex, input logic wex, input logic ld,
    input logic [4:0] rdwb, input logic wwb,
    input logic pcm, input logic thw, input logic [31:0] csr
  );
    bit e_pc, e_id, e_fid, e_fex, lu_m, hr_m;
    bit n_redir, n_halted;
    int n_fa, n_fb, n_stall, n_flush;
    rs1_ID = r1; rs1_used_ID = u1; rs2_ID = r2; rs2_used_ID = u2;
    rd_EX = rdex; WrEn_RF_EX = wex; is_load_EX = ld;
    rd_WB = rdwb; WrEn_RF_WB = wwb;
    PC_Mux_EX = pcm; tohost_we = thw; csrw_result = csr;
    #1;
    lu_m = ld && wex && (rdex != 0) && ((u1 && r1 == rdex) || (u2 && r2 == rdex));
    hr_m = thw && (csr != 0);
    n_redir = 0; n_halted = m_halted; n_stall = m_stall; n_flush = m_flush;
    if (m_halted) begin
      e_pc = 0; e_id = 0; e_fid = 1; e_fex = 1;
    end else if (hr_m) begin
      e_pc = 0; e_id = 0; e_fid = 1; e_fex = 0; n_halted = 1;
    end else if (m_redir || pcm) begin
      e_pc = 1; e_id = 1; e_fid = 1; e_fex = 0;
      n_redir = !m_redir;
      if (n_flush < SAT) n_flush++;
    end else if (lu_m) begin
      e_pc = 0; e_id = 0; e_fid = 1; e_fex = 0;
      if (n_stall < SAT) n_stall++;
    end else begin
      e_pc = 1; e_id = 1; e_fid = 0; e_fex = 0;
    end
    if (e_fid || !e_id) begin
      n_fa = 0; n_fb = 0;
    end else begin
      n_fa = fwdModel(u1, r1, rdex, wex, rdwb, wwb);
      n_fb = fwdModel(u2, r2, rdex, wex, rdwb, wwb);
    end
    pre_pc_en = pc_en; pre_id_en = id_en; pre_flush_id = flush_id; pre_flush_ex = flush_ex;
    if (!quiet) begin
      checkOutput("pc_en", pc_en, e_pc);
      checkOutput("id_en", id_en, e_id);
      checkOutput("flush_id", flush_id, e_fid);
      checkOutput("flush_ex", flush_ex, e_fex);
    end
    @(posedge clk);
    m_redir = n_redir; m_halted = n_halted; m_fwd_a = n_fa; m_fwd_b = n_fb;
    m_stall = n_stall; m_flush = n_flush;
    #1;
    if (!quiet) begin
      checkOutput("halted", halted, m_halted);
      checkOutput("fwd_a_EX", fwd_a_EX, m_fwd_a);
      checkOutput("fwd_b_EX", fwd_b_EX, m_fwd_b);
      checkOutput("stall_cycles", stall_cycles, m_stall);
      checkOutput("flush_cycles", flush_cycles, m_flush);
    end
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Assert reset for three cycles, check the reset values, release.
  task automatic doReset();
    rst_n = 1'b0;
    rs1_ID = 0; rs2_ID = 0; rs1_used_ID = 0; rs2_used_ID = 0;
    rd_EX = 0; WrEn_RF_EX = 0; is_load_EX = 0; rd_WB = 0; WrEn_RF_WB = 0;
    PC_Mux_EX = 0; tohost_we = 0; csrw_result = 0;
    #1;
    checkOutput("rst_halted_async", halted, 0);
    checkOutput("rst_fwd_a_async", fwd_a_EX, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pc_en", pc_en, 0);
    checkOutput("rst_id_en", id_en, 0);
    checkOutput("rst_flush_id", flush_id, 1);
    checkOutput("rst_flush_ex", flush_ex, 1);
    checkOutput("rst_fwd_b", fwd_b_EX, 0);
    checkOutput("rst_stall", stall_cycles, 0);
    checkOutput("rst_flush_cnt", flush_cycles, 0);
    m_redir = 0; m_halted = 0; m_fwd_a = 0; m_fwd_b = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int fc;
    int sc;
    logic [4:0] r1, r2, rdex, rdwb;
    logic u1, u2, wex, ld, wwb, pcm, thw;
    logic [31:0] csr;

    $display("[TB] start");
    doReset();

    // First cycle after release runs freely.
    idleCycle();
    checkOutput("post_rst_pc_en", pre_pc_en, 1);
    checkOutput("post_rst_id_en", pre_id_en, 1);

    // Forwarding: EX match, EX-over-WB priority, WB match, x0 never forwarded.
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("fwd_ex_match", fwd_a_EX, 2'b01);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("fwd_ex_priority", fwd_a_EX, 2'b01);
    applyStimulus(5'd9, 1'b0, 5'd9, 1'b1, 5'd3, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("fwd_wb_match", fwd_b_EX, 2'b10);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("fwd_x0", fwd_b_EX, 2'b00);

    // Load-use: one stall cycle, then the loaded value forwards from WB.
    applyStimulus(5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("lu_pc_en", pre_pc_en, 0);
    checkOutput("lu_id_en", pre_id_en, 0);
    checkOutput("lu_flush_id", pre_flush_id, 1);
    checkOutput("lu_fwd_b", fwd_b_EX, 2'b00);
    applyStimulus(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("lu_fwd_b_wb", fwd_b_EX, 2'b10);
    checkOutput("lu_stall_cnt", stall_cycles, 1);

    // Redirect: branch cycle plus REDIR, with a load-use ignored in REDIR.
    sc = stall_cycles;
    fc = flush_cycles;
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("br0_flush_id", pre_flush_id, 1);
    checkOutput("br0_pc_en", pre_pc_en, 1);
    applyStimulus(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("br1_flush_id", pre_flush_id, 1);
    checkOutput("br1_pc_en", pre_pc_en, 1);
    checkOutput("br_stall_same", stall_cycles, sc);
    checkOutput("br_flush_plus2", flush_cycles, fc + 2);
    idleCycle();
    checkOutput("br_back_run", pre_flush_id, 0);

    // Halt: zero tohost write is ignored, non-zero write halts.
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    checkOutput("tohost0_pc_en", pre_pc_en, 1);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd1);
    checkOutput("hr_pc_en", pre_pc_en, 0);
    checkOutput("hr_flush_id", pre_flush_id, 1);
    checkOutput("hr_halted", halted, 1);
    sc = stall_cycles;
    fc = flush_cycles;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(5'($urandom_range(0, 7)), 1'b1, 5'($urandom_range(0, 7)), 1'b1,
                    5'($urandom_range(1, 7)), 1'b1, 1'($urandom), 5'd0, 1'b0,
                    1'($urandom), 1'b0, 32'd0);
    end
    checkOutput("halt_flush_ex", pre_flush_ex, 1);
    checkOutput("halt_stall_frozen", stall_cycles, sc);
    checkOutput("halt_flush_frozen", flush_cycles, fc);
    doReset();
    idleCycle();
    checkOutput("halt_reset_run", pre_pc_en, 1);

    // Randomized traffic against the model (zero tohost values only).
    for (int i = 0; i < 400; i++) begin
      r1   = 5'($urandom_range(0, 7));
      r2   = 5'($urandom_range(0, 7));
      rdex = 5'($urandom_range(0, 7));
      rdwb = 5'($urandom_range(0, 7));
      u1   = 1'($urandom);
      u2   = 1'($urandom);
      wex  = ($urandom_range(0, 3) != 0);
      wwb  = 1'($urandom);
      ld   = ($urandom_range(0, 2) == 0);
      pcm  = ($urandom_range(0, 5) == 0);
      thw  = ($urandom_range(0, 3) == 0);
      csr  = thw ? 32'd0 : $urandom;
      applyStimulus(r1, u1, r2, u2, rdex, wex, ld, rdwb, wwb, pcm, thw, csr);
    end

    // Saturation: a long unbroken load-use stall pins the counter at all-ones.
    doReset();
    quiet = 1;
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    end
    quiet = 0;
    checkOutput("sat_stall", stall_cycles, 16'hFFFF);
    applyStimulus(5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("sat_stall_hold", stall_cycles, 16'hFFFF);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
